pe: RTL and testbench
=====================

PE -- requirements
Module: pe

Interface
REQ-001 Parameter d_width, default 32, data width of iact, weight, accumulator and pe_out.
REQ-002 Parameter iact_size, default 5, number of input activations per row.
REQ-003 Parameter kernel_size, default 3, number of weights per row; iact_size >= kernel_size >= 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a row operation; sampled only in IDLE.
REQ-007 iact  input  d_width  signed activation, captured during LOAD_IACT.
REQ-008 weight  input  d_width  signed weight, captured during LOAD_WEIGHT.
REQ-009 load_iact  output  1  one-cycle pulse: activation buffer full.
REQ-010 load_weight  output  1  one-cycle pulse: weight buffer full.
REQ-011 pe_out  output  d_width  most recently completed partial sum, held until the next one completes.
REQ-012 done  output  1  one-cycle pulse when the final partial sum is on pe_out.

Function
REQ-013 FSM states IDLE, LOAD_IACT, LOAD_WEIGHT, COMPUTE; IDLE->LOAD_IACT on the edge where start=1 (E0).
REQ-014 LOAD_IACT captures iact into buffer slots 0..iact_size-1 on the iact_size edges after E0 (E1..E5 at defaults).
REQ-015 load_iact is high for exactly the cycle after the last iact capture; FSM moves to LOAD_WEIGHT on that same edge.
REQ-016 LOAD_WEIGHT captures weight into slots 0..kernel_size-1 on the kernel_size edges that follow (E6..E8).
REQ-017 load_weight is high for exactly the cycle after the last weight capture; FSM moves to COMPUTE.
REQ-018 COMPUTE produces N = iact_size-kernel_size+1 outputs, O[j] = sum over k of weight[k]*iact[j+k], j = 0..N-1.
REQ-019 One multiply-accumulate per cycle; each output takes kernel_size cycles; accumulator clears between outputs.
REQ-020 pe_out updates to O[j] on the edge of its last MAC (defaults: O0 after E11, O1 after E14, O2 after E17).
REQ-021 done is high for the one cycle in which O[N-1] first appears on pe_out; FSM returns to IDLE on the same edge.
REQ-022 Arithmetic: two's-complement signed; product and sum truncated to d_width bits, wrapping modulo 2^d_width.
REQ-023 start is ignored outside IDLE; start held high in IDLE after done begins a new operation.
REQ-024 Buffers retain contents after done; pe_out holds O[N-1] until overwritten by the next operation.
REQ-025 iact_size == kernel_size gives N=1: single output, done after kernel_size compute cycles.

Reset
REQ-026 rst_n=0 immediately forces IDLE, clears buffers, accumulator and counters; pe_out=0, done=0, load_iact=0, load_weight=0.
REQ-027 Reset asserted mid-operation aborts it; no done pulse; the next operation starts only on a new start.

Configuration
REQ-028 Macro PE_RELU_EN: when defined, each O[j] with sign bit set is written to pe_out as 0; when undefined, pe_out carries the raw wrapped sum.

Verification
REQ-029 Defaults, iact 2,4,6,8,10, weights 1,2,3 -> pe_out 28, 40, 52; done with 52; load_iact one cycle after E5, load_weight one cycle after E8.
REQ-030 Weights 1,-2,1 on iact 2,4,6,8,10 -> pe_out 0,0,0 (both macro settings); weights -1,0,0 -> -2,-4,-6 undefined, 0,0,0 with PE_RELU_EN.
REQ-031 iact 0x7FFFFFFF x5, weights 1,1,0 -> pe_out 0xFFFFFFFE (wrap), no error.
REQ-032 start pulsed during LOAD_WEIGHT and COMPUTE -> no restart; outputs unchanged from REQ-029.
REQ-033 rst_n low during COMPUTE after O0 -> all outputs 0 immediately, no done; fresh start then gives 28, 40, 52.
REQ-034 iact_size=3, kernel_size=3, iact 1,2,3, weights 4,5,6 -> single pe_out 32 with done.

Source files
------------

// File: rtl/pe.sv
// Processing element for a 1-D convolution row.
// Loads iact_size activations, then kernel_size weights, then emits
// iact_size-kernel_size+1 partial sums, one multiply-accumulate per cycle.
// Optional feature: define PE_RELU_EN to clamp negative partial sums to zero.
module pe #(
    parameter int unsigned d_width     = 32,
    parameter int unsigned iact_size   = 5,
    parameter int unsigned kernel_size = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [d_width-1:0] iact,
    input  logic [d_width-1:0] weight,
    output logic               load_iact,
    output logic               load_weight,
    output logic [d_width-1:0] pe_out,
    output logic               done
);

    localparam int unsigned IactW  = (iact_size > 1) ? $clog2(iact_size) : 1;
    localparam int unsigned KernW  = (kernel_size > 1) ? $clog2(kernel_size) : 1;
    localparam int unsigned NumOut = iact_size - kernel_size + 1;

    typedef enum logic [1:0] {StIdle, StLoadIact, StLoadWeight, StCompute} state_e;

    state_e             state_q, state_d;
    // slot_q: activation slot while loading, output index j while computing.
    logic [IactW-1:0]   slot_q, slot_d;
    // k_q: weight slot while loading, tap index within the current output while computing.
    logic [KernW-1:0]   k_q, k_d;
    logic [d_width-1:0] acc_q, acc_d;
    logic [d_width-1:0] out_q, out_d;
    logic               load_iact_q, load_iact_d;
    logic               load_weight_q, load_weight_d;
    logic               done_q, done_d;
    logic [d_width-1:0] iact_buf_q   [iact_size];
    logic [d_width-1:0] iact_buf_d   [iact_size];
    logic [d_width-1:0] weight_buf_q [kernel_size];
    logic [d_width-1:0] weight_buf_d [kernel_size];

    logic [IactW-1:0]   tap;
    logic [d_width-1:0] prod;
    logic [d_width-1:0] sum;
    logic [d_width-1:0] result;

    // MAC datapath: current tap product added to the running accumulator.
    always_comb begin
        tap  = slot_q + IactW'(k_q);
        // Low d_width bits of a product are identical for signed and unsigned operands.
        prod = weight_buf_q[k_q] * iact_buf_q[tap];
        sum  = acc_q + prod;
`ifdef PE_RELU_EN
        result = sum[d_width-1] ? '0 : sum;
`else
        result = sum;
`endif
    end

    // Next-state logic for the FSM, buffers, counters and output registers.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        k_d           = k_q;
        acc_d         = acc_q;
        out_d         = out_q;
        load_iact_d   = 1'b0;
        load_weight_d = 1'b0;
        done_d        = 1'b0;
        iact_buf_d    = iact_buf_q;
        weight_buf_d  = weight_buf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadIact;
                    slot_d  = '0;
                end
            end
            StLoadIact: begin
                iact_buf_d[slot_q] = iact;
                if (slot_q == IactW'(iact_size - 1)) begin
                    state_d     = StLoadWeight;
                    load_iact_d = 1'b1;
                    k_d         = '0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            StLoadWeight: begin
                weight_buf_d[k_q] = weight;
                if (k_q == KernW'(kernel_size - 1)) begin
                    state_d       = StCompute;
                    load_weight_d = 1'b1;
                    slot_d        = '0;
                    k_d           = '0;
                    acc_d         = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StCompute: begin
                if (k_q == KernW'(kernel_size - 1)) begin
                    out_d = result;
                    acc_d = '0;
                    k_d   = '0;
                    if (slot_q == IactW'(NumOut - 1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            slot_q        <= '0;
            k_q           <= '0;
            acc_q         <= '0;
            out_q         <= '0;
            load_iact_q   <= 1'b0;
            load_weight_q <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < int'(iact_size); i++) iact_buf_q[i] <= '0;
            for (int i = 0; i < int'(kernel_size); i++) weight_buf_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            k_q           <= k_d;
            acc_q         <= acc_d;
            out_q         <= out_d;
            load_iact_q   <= load_iact_d;
            load_weight_q <= load_weight_d;
            done_q        <= done_d;
            iact_buf_q    <= iact_buf_d;
            weight_buf_q  <= weight_buf_d;
        end
    end

    assign load_iact   = load_iact_q;
    assign load_weight = load_weight_q;
    assign pe_out      = out_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed and random rows against a
// convolution model computed from the arithmetic definition.
module tb_pe;
    localparam int unsigned W  = 32;
    localparam int unsigned IS = 5;
    localparam int unsigned KS = 3;
    localparam int unsigned N  = IS - KS + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, s_start;
    logic [W-1:0] iact, weight, s_iact, s_weight;
    logic [W-1:0] pe_out, s_pe_out;
    logic         load_iact, load_weight, done;
    logic         s_load_iact, s_load_weight, s_done;

    always #5 clk = ~clk;

    pe #(.d_width(W), .iact_size(IS), .kernel_size(KS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iact(iact), .weight(weight),
        .load_iact(load_iact), .load_weight(load_weight), .pe_out(pe_out), .done(done)
    );

    pe #(.d_width(W), .iact_size(3), .kernel_size(3)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .iact(s_iact), .weight(s_weight),
        .load_iact(s_load_iact), .load_weight(s_load_weight), .pe_out(s_pe_out),
        .done(s_done)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_out = '0;
    logic [W-1:0] cur_ia [IS];
    logic [W-1:0] cur_w  [KS];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: O[j] = sum_k w[k]*ia[j+k], wrapped to W bits, optional clamp.
    function automatic logic [W-1:0] model_out(input int j);
        logic [W-1:0] s = '0;
        for (int k = 0; k < int'(KS); k++) s = s + cur_w[k] * cur_ia[j + k];
`ifdef PE_RELU_EN
        if (s[W-1]) s = '0;
`endif
        return s;
    endfunction

    // One row: poke drives start high outside IDLE; abort_c>0 resets after that compute cycle.
    task automatic run_op(input bit poke, input int abort_c);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < int'(IS); i++) begin
            iact = cur_ia[i];
            step();
            chk("load_iact", W'(load_iact), W'(i == int'(IS) - 1));
            chk("hold_out_li", pe_out, exp_out);
        end
        for (int i = 0; i < int'(KS); i++) begin
            weight = cur_w[i];
            start  = poke;
            step();
            chk("load_weight", W'(load_weight), W'(i == int'(KS) - 1));
            chk("load_iact_lw", W'(load_iact), '0);
        end
        for (int c = 1; c <= int'(N * KS); c++) begin
            start = poke;
            step();
            if (c % int'(KS) == 0) exp_out = model_out(c / int'(KS) - 1);
            chk("pe_out", pe_out, exp_out);
            chk("done", W'(done), W'(c == int'(N * KS)));
            if (c == abort_c) begin
                start   = 1'b0;
                rst_n   = 1'b0;
                #1;
                exp_out = '0;
                chk("rst_out", pe_out, '0);
                chk("rst_done", W'(done), '0);
                chk("rst_lw", W'(load_weight), '0);
                step();
                rst_n = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    step();
                    chk("post_rst_done", W'(done), '0);
                    chk("post_rst_out", pe_out, '0);
                    chk("post_rst_li", W'(load_iact), '0);
                end
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_check;
        step();
        chk("idle_done", W'(done), '0);
        chk("idle_out", pe_out, exp_out);
    endtask

    task automatic set_ref;
        for (int i = 0; i < int'(IS); i++) cur_ia[i] = W'(2 * (i + 1));
        cur_w[0] = 32'd1; cur_w[1] = 32'd2; cur_w[2] = 32'd3;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; iact = '0; weight = '0;
        s_start = 1'b0; s_iact = '0; s_weight = '0;
        step(); step();
        chk("reset_out", pe_out, '0);
        chk("reset_done", W'(done), '0);
        chk("reset_li", W'(load_iact), '0);
        chk("reset_lw", W'(load_weight), '0);
        rst_n = 1'b1;
        step();

        // Reference row: 28, 40, 52.
        set_ref();
        run_op(1'b0, 0);
        chk("ref_last", pe_out, 32'd52);
        idle_check();

        // Back-to-back with start held: a new row begins right after done.
        cur_w[0] = 32'd1; cur_w[1] = 32'hFFFF_FFFE; cur_w[2] = 32'd1;
        run_op(1'b0, 0);
        chk("zero_last", pe_out, '0);
        cur_w[0] = 32'hFFFF_FFFF; cur_w[1] = '0; cur_w[2] = '0;
        run_op(1'b0, 0);
        idle_check();

        // Wrap-around.
        for (int i = 0; i < int'(IS); i++) cur_ia[i] = 32'h7FFF_FFFF;
        cur_w[0] = 32'd1; cur_w[1] = 32'd1; cur_w[2] = '0;
        run_op(1'b0, 0);
        idle_check();

        // start pulsed during load-weight and compute is ignored.
        set_ref();
        run_op(1'b1, 0);
        chk("poke_last", pe_out, 32'd52);
        idle_check();
        idle_check();

        // Reset after O0 aborts the row; a fresh row still gives 28, 40, 52.
        run_op(1'b0, 5);
        run_op(1'b0, 0);
        chk("post_abort_last", pe_out, 32'd52);
        idle_check();

        // Random rows.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(IS); i++) cur_ia[i] = W'($urandom);
            for (int k = 0; k < int'(KS); k++)
                cur_w[k] = $urandom_range(0, 1) ? W'($urandom)
                                                : W'($urandom_range(0, 20)) - 32'd10;
            run_op(1'(r % 2), 0);
            if (r % 3 == 0) idle_check();
        end

        // Single-output configuration: 4*1 + 5*2 + 6*3 = 32.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_iact = W'(i + 1);
            step();
            chk("s_load_iact", W'(s_load_iact), W'(i == 2));
        end
        for (int i = 0; i < 3; i++) begin
            s_weight = W'(i + 4);
            step();
            chk("s_load_weight", W'(s_load_weight), W'(i == 2));
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("s_pe_out", s_pe_out, (c == 3) ? 32'd32 : 32'd0);
            chk("s_done", W'(s_done), W'(c == 3));
        end
        step();
        chk("s_done_clear", W'(s_done), '0);
        chk("s_hold", s_pe_out, 32'd32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
